cpu_boot_ctrl: RTL and testbench
================================

Name: cpu_boot_ctrl

Overview:
Parametrised CPU boot/supervisor controller; next generation of the CPU driver. On a start pulse it streams LOAD_WORDS words from a valid/ready source into data memory through the CPU's external write port, holding the CPU in reset. It then releases the CPU, snoops the CPU data-memory write bus for a write to RESULT_ADDR, latches the result onto final_output, and re-asserts CPU reset. Sits beside cpu, between the board-level start input and the core.

Parameters:
DATA_W, 32, data word width
ADDR_W, 32, byte-address width
LOAD_WORDS, 16, words loaded per boot (>=1)
LOAD_BASE, 32'h0, byte address of first loaded word
RESULT_ADDR, 32'h64, CPU store address that ends the run
OUT_W, 8, final_output width (<= DATA_W)
TIMEOUT_CYC, 4096, run-phase cycle limit (only with CPU_BOOT_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
CPU_start  in  1  start request, sampled high in IDLE/DONE
ld_valid  in  1  load stream word valid
ld_data  in  DATA_W  load stream word
ld_ready  out  1  load stream ready
cpu_reset  out  1  active-high reset driven to cpu
Ext_MemWrite  out  1  external data-memory write enable
Ext_WriteData  out  DATA_W  external write data
Ext_DataAdr  out  ADDR_W  external write byte address
MemWrite  in  1  CPU data-memory write enable (snoop)
WriteData  in  DATA_W  CPU write data (snoop)
DataAdr  in  ADDR_W  CPU write address (snoop)
final_output  out  OUT_W  latched result
busy  out  1  high in LOAD or RUN
done  out  1  high in DONE
timeout  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, async): state IDLE; cpu_reset=1; Ext_MemWrite=0; Ext_WriteData=0; Ext_DataAdr=0; ld_ready=0; final_output=0; busy=0; done=0; timeout=0; word counter=0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: cpu_reset=1. CPU_start=1 -> LOAD next cycle, counter=0, timeout cleared.
- LOAD: ld_ready=1; cpu_reset=1. Each cycle with ld_valid&ld_ready: register Ext_MemWrite=1, Ext_WriteData=ld_data, Ext_DataAdr=LOAD_BASE+4*counter (ADDR_W modulo, wraps silently); counter++. Ext_MemWrite is one-cycle, registered (write visible at memory one cycle after handshake). No handshake -> Ext_MemWrite=0, address/data hold. After handshake with counter==LOAD_WORDS-1 -> RUN; ld_ready drops the same edge.
- RUN: cpu_reset=0 from first RUN cycle; ld_ready=0; Ext_MemWrite=0. Cycle with MemWrite=1 and DataAdr==RESULT_ADDR: final_output<=WriteData[OUT_W-1:0], cpu_reset<=1, -> DONE. Other CPU writes ignored.
- DONE: done=1, cpu_reset=1, final_output held. CPU_start=1 -> LOAD (new boot; final_output held until overwritten).
- CPU_start outside IDLE/DONE ignored. ld_valid outside LOAD ignored (not consumed).
- Result write and timeout expiry same cycle: result wins, timeout stays 0.
- reset asserted mid-LOAD/RUN: immediate return to reset values; partially loaded memory is not cleaned.

Optional Feature:
CPU_BOOT_TIMEOUT_EN: defined -> 16-bit-min run counter cleared on RUN entry; when it reaches TIMEOUT_CYC-1 without result write: timeout<=1, cpu_reset<=1, final_output<={OUT_W{1'b1}}, -> DONE. Not defined -> no counter, RUN waits indefinitely, timeout tied 0, TIMEOUT_CYC unused.

Decomposition:
- Package cpu_boot_pkg: state enum (IDLE/LOAD/RUN/DONE, 2-bit), WORD_BYTES=4 constant, counter-width function clog2.
- One sub-module natural: cpu_boot_loader (LOAD-phase handshake, counter, address generation, registered Ext_* outputs); FSM and snoop in top.

Test Plan:
- Reset then CPU_start, LOAD_WORDS=4, ld_valid held 1, data A0..A3 -> Ext writes to 0x0,0x4,0x8,0xC on 4 consecutive cycles; cpu_reset falls next cycle.
- ld_valid toggled 1/0 per cycle -> exactly 4 writes, addresses contiguous, no gaps in counter, no duplicate words.
- RUN, CPU writes 0x1234_56AB to 0x60 then to 0x64 -> first ignored; final_output=0xAB, done=1, cpu_reset=1 the cycle after second write.
- DONE then CPU_start with new stream -> second boot reloads 4 words from LOAD_BASE; final_output stays 0xAB until new result.
- reset pulsed low after 2 of 4 load words -> all outputs reset asynchronously; next start reloads from word 0 at LOAD_BASE.
- CPU_BOOT_TIMEOUT_EN, TIMEOUT_CYC=16, no result write -> after 16 RUN cycles timeout=1, final_output=0xFF, done=1; result write on cycle 16 instead -> timeout=0.

Source files
------------

// File: rtl/cpu_boot_ctrl_pkg.sv
// cpu_boot_ctrl shared types: boot FSM states,
// word size and a constant-width helper.
package cpu_boot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Boot controller bus bundle: load stream,
// external memory write port and CPU store snoop.
interface cpu_boot_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              Ext_MemWrite;
  logic [DATA_W-1:0] Ext_WriteData;
  logic [ADDR_W-1:0] Ext_DataAdr;
  logic              MemWrite;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] DataAdr;

  modport master (
    input  ld_valid, ld_data,
    input  MemWrite, WriteData, DataAdr,
    output ld_ready,
    output Ext_MemWrite, Ext_WriteData,
    output Ext_DataAdr
  );

  modport slave (
    output ld_valid, ld_data,
    output MemWrite, WriteData, DataAdr,
    input  ld_ready,
    input  Ext_MemWrite, Ext_WriteData,
    input  Ext_DataAdr
  );
endinterface

// File: rtl/cpu_boot_ctrl_loader.sv
// Load phase: stream handshake, word counter and
// registered external memory writes.
module cpu_boot_loader
  import cpu_boot_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LOAD_WORDS = 16,
  parameter logic [ADDR_W-1:0] LOAD_BASE = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  cpu_boot_ctrl_if.master bus,
  output logic            last
);

  localparam int CL = clog2(LOAD_WORDS);
  localparam int CW = (CL < 1) ? 1 : CL;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic              hs;

  assign hs   = en & bus.ld_valid;
  assign last = hs && (cnt_q == CW'(LOAD_WORDS - 1));

  always_comb begin
    cnt_d = cnt_q;
    we_d  = hs;
    wd_d  = wd_q;
    wa_d  = wa_q;
    if (hs) begin
      wd_d  = bus.ld_data;
      wa_d  = LOAD_BASE
            + ADDR_W'(cnt_q) * ADDR_W'(WORD_BYTES);
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      we_q  <= 1'b0;
      wd_q  <= '0;
      wa_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      we_q  <= we_d;
      wd_q  <= wd_d;
      wa_q  <= wa_d;
    end
  end

  assign bus.ld_ready      = en;
  assign bus.Ext_MemWrite  = we_q;
  assign bus.Ext_WriteData = wd_q;
  assign bus.Ext_DataAdr   = wa_q;

endmodule

// File: rtl/cpu_boot_ctrl.sv
// CPU boot/supervisor: load, run, snoop result.
// Optional run timeout via CPU_BOOT_TIMEOUT_EN.
module cpu_boot_ctrl
  import cpu_boot_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int LOAD_WORDS  = 16,
  parameter logic [ADDR_W-1:0] LOAD_BASE   = '0,
  parameter logic [ADDR_W-1:0] RESULT_ADDR = 'h64,
  parameter int OUT_W       = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CPU_start,
  cpu_boot_ctrl_if.master  bus,
  output logic             cpu_reset,
  output logic [OUT_W-1:0] final_output,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  state_t           state_q, state_d;
  logic [OUT_W-1:0] final_q, final_d;
  logic             timeout_q, timeout_d;
  logic             ld_last;
  logic             res_hit;
  logic             to_hit;

  cpu_boot_loader #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .LOAD_WORDS (LOAD_WORDS),
    .LOAD_BASE  (LOAD_BASE)
  ) u_loader (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == LOAD),
    .bus   (bus),
    .last  (ld_last)
  );

`ifdef CPU_BOOT_TIMEOUT_EN
  localparam int TL = clog2(TIMEOUT_CYC);
  localparam int TW = (TL > 16) ? TL : 16;

  logic [TW-1:0] run_cnt_q, run_cnt_d;

  // Zero outside RUN, so every RUN entry starts from 0
  assign run_cnt_d = (state_q == RUN)
                   ? run_cnt_q + 1'b1 : '0;
  assign to_hit    = (state_q == RUN)
                   && (run_cnt_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_cnt_q <= '0;
    else        run_cnt_q <= run_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  assign res_hit = bus.MemWrite
                && (bus.DataAdr == RESULT_ADDR);

  always_comb begin
    state_d   = state_q;
    final_d   = final_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (CPU_start) begin
          state_d   = LOAD;
          timeout_d = 1'b0;
        end
      end
      LOAD: begin
        if (ld_last) state_d = RUN;
      end
      RUN: begin
        // Result store beats a same-cycle timeout
        if (res_hit) begin
          final_d = bus.WriteData[OUT_W-1:0];
          state_d = DONE;
        end else if (to_hit) begin
          final_d   = '1;
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      final_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      final_q   <= final_d;
      timeout_q <= timeout_d;
    end
  end

  assign cpu_reset    = (state_q != RUN);
  assign busy         = (state_q == LOAD)
                     || (state_q == RUN);
  assign done         = (state_q == DONE);
  assign final_output = final_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Bench for cpu_boot_ctrl: phase-level model with
// per-cycle compare plus literal checks.
module tb_cpu_boot_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 4;
  localparam int OW = 8;
  localparam int TC = 16;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] RES  = 32'h64;
`ifdef CPU_BOOT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          CPU_start = 1'b0;
  logic          cpu_reset;
  logic [OW-1:0] final_output;
  logic          busy;
  logic          done;
  logic          timeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_boot_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  cpu_boot_ctrl #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .LOAD_WORDS  (LW),
    .LOAD_BASE   (BASE),
    .RESULT_ADDR (RES),
    .OUT_W       (OW),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .CPU_start    (CPU_start),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .final_output (final_output),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Phase model: 0 idle, 1 load, 2 run, 3 done
  int          m_phase = 0;
  int          m_cnt   = 0;
  int          m_run   = 0;
  bit          m_to    = 1'b0;
  bit          m_we    = 1'b0;
  logic [31:0] m_wd    = '0;
  logic [31:0] m_wa    = '0;
  logic [7:0]  m_final = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_cnt = 0; m_run = 0;
      m_to = 0; m_we = 0;
      m_wd = '0; m_wa = '0; m_final = '0;
    end else begin
      m_we = 1'b0;
      case (m_phase)
        0, 3: if (CPU_start) begin
          m_phase = 1; m_cnt = 0; m_to = 0;
        end
        1: if (bus.ld_valid) begin
          m_we = 1'b1;
          m_wd = bus.ld_data;
          m_wa = BASE + 32'(4 * m_cnt);
          m_cnt++;
          if (m_cnt == LW) begin
            m_phase = 2; m_run = 0;
          end
        end
        2: begin
          m_run++;
          if (bus.MemWrite && bus.DataAdr == RES) begin
            m_final = bus.WriteData[7:0];
            m_phase = 3;
          end else if (TO_EN && m_run == TC) begin
            m_final = 8'hFF;
            m_to    = 1'b1;
            m_phase = 3;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("ld_ready", bus.ld_ready, m_phase == 1);
    chk("cpu_reset", cpu_reset, m_phase != 2);
    chk("busy", busy, m_phase == 1 || m_phase == 2);
    chk("done", done, m_phase == 3);
    chk("ext_we", bus.Ext_MemWrite, m_we);
    chk("ext_data", bus.Ext_WriteData, m_wd);
    chk("ext_adr", bus.Ext_DataAdr, m_wa);
    chk("final", final_output, m_final);
    chk("timeout", timeout, m_to);
  end

  logic [63:0] wq[$];
  always @(negedge clk)
    if (bus.Ext_MemWrite)
      wq.push_back({bus.Ext_DataAdr, bus.Ext_WriteData});

  logic [31:0] ADR[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] DA[4]  = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
  logic [31:0] DB[4]  = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
  logic [31:0] DD[4]  = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};

  task automatic expect_writes(input logic [31:0] d[4]);
    chk("wr_count", wq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wq.size()) begin
        chk("wr_adr", wq[i][63:32], ADR[i]);
        chk("wr_data", wq[i][31:0], d[i]);
      end
    end
    wq.delete();
  endtask

  task automatic start_pulse();
    CPU_start = 1'b1;
    @(negedge clk);
    CPU_start = 1'b0;
  endtask

  task automatic load_solid(input logic [31:0] d[4]);
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = d[i];
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a,
                           input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = a;
    bus.WriteData = d;
    @(negedge clk);
    bus.MemWrite  = 1'b0;
  endtask

  initial begin
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.MemWrite  = 1'b0;
    bus.WriteData = '0;
    bus.DataAdr   = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", bus.ld_ready, 0);
    chk("rst_ext_we", bus.Ext_MemWrite, 0);
    reset = 1'b1;
    @(negedge clk);

    // Boot 1: solid stream, result after ignored store
    start_pulse();
    chk("load_ready", bus.ld_ready, 1);
    chk("load_cpu_reset", cpu_reset, 1);
    load_solid(DA);
    chk("run_cpu_reset", cpu_reset, 0);
    chk("last_we", bus.Ext_MemWrite, 1);
    chk("last_adr", bus.Ext_DataAdr, 32'hC);
    chk("last_data", bus.Ext_WriteData, 32'hA3);
    repeat (2) @(negedge clk);
    expect_writes(DA);
    cpu_write(32'h60, 32'h1234_56AB);
    chk("ignored_done", done, 0);
    chk("ignored_final", final_output, 8'h00);
    cpu_write(32'h64, 32'h1234_56AB);
    chk("res_final", final_output, 8'hAB);
    chk("res_done", done, 1);
    chk("res_cpu_reset", cpu_reset, 1);

    // Stray stream word in DONE is not consumed
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hEE;
    @(negedge clk);
    bus.ld_valid = 1'b0;

    // Boot 2: toggled valid, start pulse during LOAD
    start_pulse();
    for (int k = 0; k < 8; k++) begin
      bus.ld_valid = (k % 2 == 0);
      bus.ld_data  = (k % 2 == 0) ? DB[k/2]
                   : 32'hDEAD_0000 + 32'(k);
      CPU_start = (k == 1);
      if (k == 3)
        chk("final_held", final_output, 8'hAB);
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    CPU_start = 1'b0;
    repeat (2) @(negedge clk);
    expect_writes(DB);
    cpu_write(32'h64, 32'h0000_005C);
    chk("boot2_final", final_output, 8'h5C);

    // Async reset after two of four words
    start_pulse();
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hC0;
    @(negedge clk);
    bus.ld_data  = 32'hC1;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cpu_reset", cpu_reset, 1);
    chk("arst_ext_we", bus.Ext_MemWrite, 0);
    chk("arst_ext_adr", bus.Ext_DataAdr, 0);
    chk("arst_ext_data", bus.Ext_WriteData, 0);
    chk("arst_final", final_output, 0);
    @(negedge clk);
    reset = 1'b1;
    wq.delete();
    @(negedge clk);
    start_pulse();
    load_solid(DD);
    repeat (2) @(negedge clk);
    expect_writes(DD);
    cpu_write(32'h64, 32'h0000_0011);
    chk("reload_final", final_output, 8'h11);

`ifdef CPU_BOOT_TIMEOUT_EN
    start_pulse();
    load_solid(DA);
    repeat (15) @(negedge clk);
    chk("to_pre_busy", busy, 1);
    chk("to_pre_flag", timeout, 0);
    @(negedge clk);
    chk("to_flag", timeout, 1);
    chk("to_final", final_output, 8'hFF);
    chk("to_done", done, 1);
    start_pulse();
    chk("to_cleared", timeout, 0);
    load_solid(DA);
    repeat (15) @(negedge clk);
    cpu_write(32'h64, 32'h0000_0077);
    chk("race_flag", timeout, 0);
    chk("race_final", final_output, 8'h77);
    chk("race_done", done, 1);
`else
    start_pulse();
    load_solid(DA);
    repeat (40) @(negedge clk);
    chk("wait_busy", busy, 1);
    chk("wait_flag", timeout, 0);
    cpu_write(32'h64, 32'h0000_0042);
    chk("wait_final", final_output, 8'h42);
`endif
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
